// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - parametrised parallel CRC engine over a framed valid/ready stream
// One beat is folded per clock; the finalised CRC and byte count are held until accepted.
module crc_stream_engine #(
  parameter int                   CRC_WIDTH  = 16,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] XOROUT     = 16'h0000,
  parameter bit                   REFIN      = 1'b0,
  parameter bit                   REFOUT     = 1'b0,
  parameter int                   LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CRC_WIDTH-1:0]  crc_init,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [((DATA_WIDTH/8) > 1 ? $clog2(DATA_WIDTH/8) : 1)-1:0] in_bytes,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CRC_WIDTH-1:0]  out_crc,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  busy
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int CNTW = $clog2(NB + 1);
  localparam int SW   = ((LEN_WIDTH > CNTW) ? LEN_WIDTH : CNTW) + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("crc_stream_engine: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (CRC_WIDTH < 2) begin : g_bad_crc_width
    $error("crc_stream_engine: CRC_WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   out_valid_q, out_valid_d;
  logic [CRC_WIDTH-1:0]   out_crc_q, out_crc_d;
  logic [LEN_WIDTH-1:0]   out_len_q, out_len_d;
  logic                   ready_en_q;

  logic [CNTW-1:0]        beat_lanes;
  logic [CRC_WIDTH-1:0]   crc_v;
  logic [7:0]             byte_v;
  logic                   fb;
  logic [CRC_WIDTH-1:0]   crc_next;
  logic [CRC_WIDTH-1:0]   crc_final;
  logic [SW-1:0]          len_sum;
  logic [LEN_WIDTH-1:0]   len_base;
  logic [LEN_WIDTH-1:0]   len_next;
  logic                   accept;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = x[7-k];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] x);
    logic [CRC_WIDTH-1:0] r;
    for (int k = 0; k < CRC_WIDTH; k++) r[k] = x[CRC_WIDTH-1-k];
    return r;
  endfunction

  // in_bytes only trims the last beat; 0 or out-of-range means the whole beat
  always_comb begin
    beat_lanes = CNTW'(NB);
    if (in_last && (in_bytes != '0) && (int'(in_bytes) < NB)) begin
      beat_lanes = CNTW'(in_bytes);
    end
  end

  always_comb begin
    crc_v  = (state_q == IDLE) ? crc_init : crc_q;
    byte_v = '0;
    fb     = 1'b0;
    for (int i = 0; i < NB; i++) begin
      byte_v = in_data[DATA_WIDTH-1-8*i -: 8];
      if (REFIN) byte_v = rev8(byte_v);
      if (i < int'(beat_lanes)) begin
        for (int b = 7; b >= 0; b--) begin
          fb    = crc_v[CRC_WIDTH-1] ^ byte_v[b];
          crc_v = {crc_v[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
      end
    end
    crc_next = crc_v;
  end

  assign crc_final = (REFOUT ? rev_crc(crc_next) : crc_next) ^ XOROUT;

  assign len_base = (state_q == IDLE) ? '0 : len_q;
  assign len_sum  = SW'(len_base) + SW'(beat_lanes);
  assign len_next = (len_sum > SW'(LEN_MAX)) ? LEN_MAX : len_sum[LEN_WIDTH-1:0];

  // abort masks the handshake so a beat offered alongside it is never consumed
  assign in_ready = ready_en_q && (state_q != HOLD) && !abort;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_crc_d   = out_crc_q;
    out_len_d   = out_len_q;
    case (state_q)
      IDLE, RUN: begin
        if (abort) begin
          state_d = IDLE;
          crc_d   = '0;
          len_d   = '0;
        end else if (accept) begin
          crc_d = crc_next;
          len_d = len_next;
          if (in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_crc_d   = crc_final;
            out_len_d   = len_next;
          end else begin
            state_d = RUN;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          crc_d       = '0;
          len_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_crc_q   <= '0;
      out_len_q   <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_crc_q   <= out_crc_d;
      out_len_q   <= out_len_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign out_len   = out_len_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - directed bench for crc_stream_engine
// Four 32-bit-beat configurations share one input bus; a CRC-8 byte-wide instance has its own.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v32 = 1'b0, l32 = 1'b0, ab32 = 1'b0, or32 = 1'b0;
  logic [31:0] d32 = '0;
  logic [1:0]  b32 = '0;
  logic        v8 = 1'b0, l8 = 1'b0, ab8 = 1'b0, or8 = 1'b0;
  logic [7:0]  d8 = '0;
  logic [0:0]  b8 = '0;

  logic        r16, ov16, busy16;
  logic [15:0] crc16, len16;
  logic        r32, ov32, busy32;
  logic [31:0] crc32;
  logic [15:0] len32;
  logic        rarc, ovarc, busyarc;
  logic [15:0] crcarc, lenarc;
  logic        rlen, ovlen, busylen;
  logic [15:0] crclen;
  logic [3:0]  lenlen;
  logic        r8, ov8, busy8;
  logic [7:0]  crc8;
  logic [15:0] len8;

  crc_stream_engine u16 (
    .clk(clk), .rst(rst), .crc_init(16'hFFFF), .in_valid(v32), .in_ready(r16),
    .in_data(d32), .in_last(l32), .in_bytes(b32), .abort(ab32), .out_valid(ov16),
    .out_ready(or32), .out_crc(crc16), .out_len(len16), .busy(busy16));

  crc_stream_engine #(.CRC_WIDTH(32), .POLY(32'h04C11DB7), .XOROUT(32'hFFFFFFFF),
                      .REFIN(1'b1), .REFOUT(1'b1)) u32 (
    .clk(clk), .rst(rst), .crc_init(32'hFFFFFFFF), .in_valid(v32), .in_ready(r32),
    .in_data(d32), .in_last(l32), .in_bytes(b32), .abort(ab32), .out_valid(ov32),
    .out_ready(or32), .out_crc(crc32), .out_len(len32), .busy(busy32));

  crc_stream_engine #(.POLY(16'h8005), .REFIN(1'b1), .REFOUT(1'b1)) uarc (
    .clk(clk), .rst(rst), .crc_init(16'h0000), .in_valid(v32), .in_ready(rarc),
    .in_data(d32), .in_last(l32), .in_bytes(b32), .abort(ab32), .out_valid(ovarc),
    .out_ready(or32), .out_crc(crcarc), .out_len(lenarc), .busy(busyarc));

  crc_stream_engine #(.LEN_WIDTH(4)) ulen (
    .clk(clk), .rst(rst), .crc_init(16'hFFFF), .in_valid(v32), .in_ready(rlen),
    .in_data(d32), .in_last(l32), .in_bytes(b32), .abort(ab32), .out_valid(ovlen),
    .out_ready(or32), .out_crc(crclen), .out_len(lenlen), .busy(busylen));

  crc_stream_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8), .POLY(8'h07), .XOROUT(8'h00)) u8 (
    .clk(clk), .rst(rst), .crc_init(8'h00), .in_valid(v8), .in_ready(r8),
    .in_data(d8), .in_last(l8), .in_bytes(b8), .abort(ab8), .out_valid(ov8),
    .out_ready(or8), .out_crc(crc8), .out_len(len8), .busy(busy8));

  task automatic beat32(input logic [31:0] dat, input logic last, input logic [1:0] nb);
    int t;
    t = 0;
    v32 = 1'b1; d32 = dat; l32 = last; b32 = nb;
    #1;
    while (r16 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL beat32_wait: in_ready=%b required 1 within 20 cycles", r16);
    end
    @(negedge clk);
    v32 = 1'b0; l32 = 1'b0; b32 = '0;
  endtask

  task automatic beat8(input logic [7:0] dat, input logic last);
    int t;
    t = 0;
    v8 = 1'b1; d8 = dat; l8 = last; b8 = '0;
    #1;
    while (r8 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL beat8_wait: in_ready=%b required 1 within 20 cycles", r8);
    end
    @(negedge clk);
    v8 = 1'b0; l8 = 1'b0;
  endtask

  task automatic frame32();
    beat32(32'h31323334, 1'b0, 2'd0);
    beat32(32'h35363738, 1'b0, 2'd0);
    beat32(32'h39AABBCC, 1'b1, 2'd1);
  endtask

  task automatic take32();
    or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy16); end
    checks++; if (crc16 !== 16'h0000) begin errors++; $display("FAIL reset_out_crc: got %h expected 0000", crc16); end
    checks++; if (len16 !== 16'd0) begin errors++; $display("FAIL reset_out_len: got %0d expected 0", len16); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", r16); end
    checks++; if (r8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b expected 1", r8); end
  endtask

  task automatic test_crc8();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL crc8_early_valid: got %b expected 0", ov8); end
      end
      beat8(8'(32'h31 + i), (i == 8));
    end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL crc8_valid: got %b expected 1", ov8); end
    checks++; if (crc8 !== 8'hF4) begin errors++; $display("FAIL crc8_value: got %h expected f4", crc8); end
    checks++; if (len8 !== 16'd9) begin errors++; $display("FAIL crc8_len: got %0d expected 9", len8); end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL crc8_release: got %b expected 0", ov8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL crc8_busy: got %b expected 0", busy8); end
  endtask

  task automatic test_frame32();
    beat32(32'h31323334, 1'b0, 2'd0);
    beat32(32'h35363738, 1'b0, 2'd0);
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL f32_early_valid: got %b expected 0", ov16); end
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL f32_busy_run: got %b expected 1", busy16); end
    beat32(32'h39AABBCC, 1'b1, 2'd1);
    checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL f32_valid: got %b expected 1", ov16); end
    checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL ccitt_value: got %h expected 29b1", crc16); end
    checks++; if (len16 !== 16'd9) begin errors++; $display("FAIL ccitt_len: got %0d expected 9", len16); end
    checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL crc32_value: got %h expected cbf43926", crc32); end
    checks++; if (crcarc !== 16'hBB3D) begin errors++; $display("FAIL arc_value: got %h expected bb3d", crcarc); end
    checks++; if (lenlen !== 4'd9) begin errors++; $display("FAIL len4_value: got %0d expected 9", lenlen); end
    checks++; if (r16 !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", r16); end
    take32();
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL f32_release: got %b expected 0", ov16); end
  endtask

  task automatic test_backpressure();
    frame32();
    v32 = 1'b1; d32 = 32'hDEADBEEF; l32 = 1'b1; b32 = 2'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (r16 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, r16); end
      checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL bp_crc[%0d]: got %h expected 29b1", c, crc16); end
      checks++; if (len16 !== 16'd9) begin errors++; $display("FAIL bp_len[%0d]: got %0d expected 9", c, len16); end
      checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, ov16); end
    end
    or32 = 1'b1; d32 = 32'h31323334; l32 = 1'b0;
    @(negedge clk);
    or32 = 1'b0;
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", ov16); end
    checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", r16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL bp_no_passthrough: got busy %b expected 0", busy16); end
    frame32();
    checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL bp_next_crc: got %h expected 29b1", crc16); end
    checks++; if (crc32 !== 32'hCBF43926) begin errors++; $display("FAIL bp_next_crc32: got %h expected cbf43926", crc32); end
    take32();
  endtask

  task automatic test_abort();
    beat32(32'h31323334, 1'b0, 2'd0);
    beat32(32'h35363738, 1'b0, 2'd0);
    v32 = 1'b1; d32 = 32'h39AABBCC; l32 = 1'b1; b32 = 2'd1; ab32 = 1'b1;
    #1;
    checks++; if (r16 !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b expected 0", r16); end
    @(negedge clk);
    ab32 = 1'b0; v32 = 1'b0; l32 = 1'b0; b32 = '0;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy16); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", ov16); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0", ov16); end
    frame32();
    checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL abort_next_crc: got %h expected 29b1", crc16); end
    checks++; if (len16 !== 16'd9) begin errors++; $display("FAIL abort_next_len: got %0d expected 9", len16); end
    ab32 = 1'b1;
    @(negedge clk);
    ab32 = 1'b0;
    checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL hold_abort_valid: got %b expected 1", ov16); end
    checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL hold_abort_crc: got %h expected 29b1", crc16); end
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL hold_abort_busy: got %b expected 1", busy16); end
    take32();
  endtask

  task automatic test_reset_mid();
    beat32(32'h31323334, 1'b0, 2'd0);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy16); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", ov16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy16); end
    checks++; if (crc16 !== 16'h0000) begin errors++; $display("FAIL mid_rst_crc: got %h expected 0000", crc16); end
    checks++; if (crc32 !== 32'h0) begin errors++; $display("FAIL mid_rst_crc32: got %h expected 00000000", crc32); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame32();
    checks++; if (crc16 !== 16'h29B1) begin errors++; $display("FAIL mid_next_crc: got %h expected 29b1", crc16); end
    checks++; if (crcarc !== 16'hBB3D) begin errors++; $display("FAIL mid_next_arc: got %h expected bb3d", crcarc); end
    checks++; if (len16 !== 16'd9) begin errors++; $display("FAIL mid_next_len: got %0d expected 9", len16); end
    take32();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) beat32(32'h41424344, 1'b0, 2'd0);
    beat32(32'h41424344, 1'b1, 2'd0);
    checks++; if (lenlen !== 4'd15) begin errors++; $display("FAIL len_saturate: got %0d expected 15", lenlen); end
    checks++; if (len16 !== 16'd20) begin errors++; $display("FAIL len_full_beat: got %0d expected 20", len16); end
    checks++; if (ovlen !== 1'b1) begin errors++; $display("FAIL len_valid: got %b expected 1", ovlen); end
    take32();
  endtask

  initial begin
    test_reset();
    test_crc8();
    test_frame32();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised, fully parallel CRC engine. Generalises the fixed 4-bit/5-bit single-shot CRC calculator to any polynomial and width, multi-beat frames and byte-granular last beats.
- Accepts a framed data stream through a valid/ready handshake and folds one beat per clock into the CRC register.
- Presents the finalised CRC (reflection and XOR-out applied) with a byte count, held until the consumer accepts it.
- Sits between packet sources and framing/check logic in the CRC subsystem.

Parameters:
CRC_WIDTH, 16, CRC register width (2..64)
DATA_WIDTH, 32, beat width in bits; multiple of 8, NB = DATA_WIDTH/8 byte lanes
POLY, 16'h1021, generator polynomial, implicit top bit omitted
XOROUT, 16'h0000, value XORed into final CRC
REFIN, 0, 1 = bit-reverse each input byte before processing
REFOUT, 0, 1 = bit-reverse whole CRC before XOROUT
LEN_WIDTH, 16, width of frame byte counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
crc_init  in  CRC_WIDTH  seed value, sampled on first beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept beat
in_data  in  DATA_WIDTH  beat; lane 0 = bits [DATA_WIDTH-1:DATA_WIDTH-8] = first byte in stream order
in_last  in  1  beat is last of frame
in_bytes  in  max(1,clog2(NB))  valid leading lanes on last beat; 0 or >=NB = full beat
abort  in  1  discard current frame
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_crc  out  CRC_WIDTH  final CRC
out_len  out  LEN_WIDTH  frame length in bytes, saturating
busy  out  1  frame in progress (state RUN or HOLD)

Behaviour:
- Reset (async, rst=1): state IDLE, crc reg 0, len 0, out_valid 0, out_crc 0, out_len 0, busy 0. in_ready is 1 one cycle after rst deasserts.
- States:
  - IDLE: no frame open.
  - RUN: frame open, at least one beat accepted.
  - HOLD: result pending.
- in_ready = (state != HOLD). A beat is accepted when in_valid && in_ready.
- Accept in IDLE:
  - Seed = crc_init.
  - Fold beat, len = byte count of beat.
  - Go to RUN, or to HOLD if in_last.
- Accept in RUN:
  - Fold beat into crc reg, len += byte count (saturates at 2^LEN_WIDTH-1).
  - in_last moves to HOLD.
- Fold rule:
  - Process bytes lane 0 upward, each byte MSB first after optional REFIN reversal.
  - Standard non-reflected LFSR: fb = crc[MSB]^bit; crc = (crc<<1) ^ (fb ? POLY : 0).
  - On a last beat only lanes 0..in_bytes-1 are folded; in_bytes is ignored on non-last beats.
  - Implemented as a single-cycle combinational unroll, one cycle per beat.
- Finalisation on the last-beat accept edge:
  - out_crc = (REFOUT ? reverse(crc_next) : crc_next) ^ XOROUT.
  - out_len = final len, out_valid = 1.
  - Latency: result visible the cycle after the last beat is accepted.
- HOLD:
  - out_crc and out_len are stable and in_ready = 0.
  - When out_valid && out_ready: out_valid drops, state goes to IDLE, and in_ready = 1 the following cycle.
  - No same-cycle pass-through.
- abort:
  - Synchronous, priority over beat accept.
  - In RUN or IDLE: go to IDLE, crc/len cleared, no result produced; a beat presented in the same cycle is not accepted (in_ready forced 0 that cycle).
  - In HOLD: ignored, the result is already committed.
- in_valid with in_last in IDLE gives a single-beat frame; back-to-back frames have at least one idle cycle due to HOLD.
- busy = (state != IDLE).
- Mid-frame rst: everything returns to reset values immediately; the partial frame is lost.
- Widths:
  - POLY and XOROUT are CRC_WIDTH bits.
  - out_len counts bytes, not beats.
  - Elaboration error if DATA_WIDTH%8 != 0 or CRC_WIDTH < 2.

Test Plan:
1. CRC-8 config (CRC_WIDTH=8, DATA_WIDTH=8, POLY=8'h07, init 0, no reflect). Stimulus: ASCII "123456789" as 9 beats, last on 9th -> out_crc=8'hF4, out_len=9, out_valid 1 cycle after last accept.
2. Default config, init 16'hFFFF (CCITT-FALSE). Stimulus: beats 32'h31323334, 32'h35363738, 32'h39xxxxxx with in_last and in_bytes=1 -> out_crc=16'h29B1, out_len=9.
3. CRC-32 (POLY=32'h04C11DB7, init/XOROUT 32'hFFFFFFFF, REFIN=REFOUT=1, DATA_WIDTH=32). Stimulus: same "123456789" stream -> out_crc=32'hCBF43926. Also CRC-16/ARC (POLY 8005, reflect, init 0) -> 16'hBB3D.
4. Backpressure: hold out_ready=0 for 5 cycles after result, with in_valid=1 continuously -> out_crc/out_len stable, in_ready=0 throughout. Release -> out_valid drops, next frame accepted the following cycle and yields the correct CRC.
5. Abort: send 2 beats, assert abort with in_valid=1 -> no out_valid, busy=0 next cycle. A subsequent full "123456789" frame still gives 16'h29B1. abort during HOLD leaves the result intact.
6. Reset mid-frame: rst=1 asynchronously after beat 1 -> out_valid=0, busy=0, out_crc=0 immediately. After release, a new frame gives the correct CRC. Also check out_len saturation with LEN_WIDTH=4 and a 20-byte frame -> out_len=15.
